nap_countdown: RTL and testbench

NAP_COUNTDOWN -- requirements
Module: nap_countdown

---
 rtl/nap_countdown.sv | 101 ++++++++++
 tb/tb_nap_countdown.sv | 133 +++++++++++++
 2 files changed

// File: rtl/nap_countdown.sv
// nap_countdown: BCD HH:MM:SS countdown timer with pause/resume and a self-clearing alarm.
module nap_countdown #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int ALARM_LEN = 16,
  parameter int MAX_HOUR  = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        start,
  input  logic        pause,
  input  logic        alarm_ack,
  output logic [23:0] time_out,
  output logic        running,
  output logic        nonzero,
  output logic        expired,
  output logic        alarm,
  output logic        load_err
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_LEN) + 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [AW-1:0] acnt, acnt_n;
  logic [23:0] time_n, dec;
  logic [7:0] hours;
  logic load_ok, tick, exp_n, err_n, run_n, alm_n;
  logic [3:0] ht, hu, mt, mu, st, su;
  logic b_s, b_m;
  assign {ht, hu, mt, mu, st, su} = time_out;
  assign nonzero = |time_out;
  assign hours = {4'd0, load_time[23:20]} * 8'd10 + {4'd0, load_time[19:16]};
  assign load_ok = load_time[23:20] <= 4'd9 && load_time[19:16] <= 4'd9 &&
                   load_time[15:12] <= 4'd5 && load_time[11:8] <= 4'd9 &&
                   load_time[7:4] <= 4'd5 && load_time[3:0] <= 4'd9 &&
                   hours <= 8'(MAX_HOUR);
  assign tick = state == RUN && presc == PW'(TICK_DIV - 1);
  // Borrow ripples only through fields that are already 00.
  assign b_s = time_out[7:0] == 8'd0;
  assign b_m = b_s && time_out[15:8] == 8'd0;
  assign dec = {
    (!b_m || hu != 4'd0) ? ht : ht - 4'd1,
    !b_m ? hu : (hu == 4'd0 ? 4'd9 : hu - 4'd1),
    (!b_s || mu != 4'd0) ? mt : (mt == 4'd0 ? 4'd5 : mt - 4'd1),
    !b_s ? mu : (mu == 4'd0 ? 4'd9 : mu - 4'd1),
    su != 4'd0 ? st : (st == 4'd0 ? 4'd5 : st - 4'd1),
    su == 4'd0 ? 4'd9 : su - 4'd1
  };
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      acnt     <= '0;
      time_out <= '0;
      running  <= 1'b0;
      alarm    <= 1'b0;
      expired  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      acnt     <= acnt_n;
      time_out <= time_n;
      running  <= run_n;
      alarm    <= alm_n;
      expired  <= exp_n;
      load_err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    if (load)
      state_n = load_ok ? IDLE : state;
    else if (state == ALARM)
      state_n = (alarm_ack || acnt == AW'(ALARM_LEN - 1)) ? IDLE : ALARM;
    else if (state == RUN)
      state_n = pause ? PAUSE : (tick && dec == 24'd0) ? ALARM : RUN;
    else if (start && nonzero)
      state_n = RUN;
  end
  always_comb begin
    time_n  = time_out;
    presc_n = presc;
    if (load) begin
      time_n  = load_ok ? load_time : time_out;
      presc_n = load_ok ? '0 : presc;
    end else if (state == RUN && !pause) begin
      time_n  = tick ? dec : time_out;
      presc_n = tick ? '0 : presc + PW'(1);
    end else if (state == IDLE && state_n == RUN) begin
      presc_n = '0;
    end
    acnt_n = state != ALARM ? '0 : load ? acnt : acnt + AW'(1);
    exp_n  = state == RUN && state_n == ALARM;
    err_n  = load && !load_ok;
    run_n  = state_n == RUN;
    alm_n  = state_n == ALARM;
  end
endmodule

// File: tb/tb_nap_countdown.sv
// tb_nap_countdown: directed checks of nap_countdown with TICK_DIV=4, ALARM_LEN=5, MAX_HOUR=23.
module tb_nap_countdown;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0, alarm_ack = 1'b0;
  logic [23:0] load_time = '0, time_out;
  logic running, nonzero, expired, alarm, load_err;
  int n_chk = 0, n_fail = 0;
  nap_countdown #(.TICK_DIV(4), .ALARM_LEN(5), .MAX_HOUR(23)) dut (
    .clk(clk), .rst(rst), .load(load), .load_time(load_time), .start(start),
    .pause(pause), .alarm_ack(alarm_ack), .time_out(time_out), .running(running),
    .nonzero(nonzero), .expired(expired), .alarm(alarm), .load_err(load_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_load(input logic [23:0] v);
    load = 1'b1;
    load_time = v;
    step();
    load = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    step();
    step();
    chk("rst_time", time_out, 0);
    chk("rst_nonzero", nonzero, 0);
    chk("rst_running", running, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_expired", expired, 0);
    chk("rst_load_err", load_err, 0);
    rst = 1'b0;
    do_load(24'h000003);
    chk("ld3_time", time_out, 24'h000003);
    chk("ld3_nonzero", nonzero, 1);
    chk("ld3_running", running, 0);
    do_start();
    chk("run_running", running, 1);
    for (int i = 1; i <= 17; i++) begin
      step();
      chk($sformatf("cd_time_%0d", i), time_out, i >= 12 ? 0 : 3 - i / 4);
      chk($sformatf("cd_expired_%0d", i), expired, i == 12);
      chk($sformatf("cd_alarm_%0d", i), alarm, i >= 12 && i <= 16);
      chk($sformatf("cd_running_%0d", i), running, i < 12);
    end
    do_load(24'h010000);
    do_start();
    repeat (4) step();
    chk("borrow_hour", time_out, 24'h005959);
    do_load(24'h000100);
    chk("load_in_run_running", running, 0);
    do_start();
    repeat (4) step();
    chk("borrow_min", time_out, 24'h000059);
    do_load(24'h000123);
    chk("ld123_running", running, 0);
    do_load(24'h000060);
    chk("bad_sec_err", load_err, 1);
    chk("bad_sec_time", time_out, 24'h000123);
    do_load(24'h240000);
    chk("bad_hour_err", load_err, 1);
    chk("bad_hour_time", time_out, 24'h000123);
    do_load(24'h00000A);
    chk("bad_digit_err", load_err, 1);
    chk("bad_digit_time", time_out, 24'h000123);
    step();
    chk("err_pulse_end", load_err, 0);
    do_load(24'h235959);
    chk("max_hour_ok", time_out, 24'h235959);
    chk("max_hour_err", load_err, 0);
    do_load(24'h000123);
    do_start();
    step();
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("paused_running", running, 0);
    repeat (9) step();
    chk("paused_time", time_out, 24'h000123);
    do_start();
    chk("resume_running", running, 1);
    step();
    chk("resume_plus1", time_out, 24'h000123);
    step();
    chk("resume_plus2", time_out, 24'h000122);
    do_load(24'h000001);
    do_start();
    repeat (4) step();
    chk("ack_expired", expired, 1);
    chk("ack_alarm1", alarm, 1);
    chk("ack_time0", time_out, 0);
    step();
    chk("ack_alarm2", alarm, 1);
    chk("ack_exp_gone", expired, 0);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("ack_alarm_off", alarm, 0);
    chk("ack_running", running, 0);
    do_start();
    chk("start_zero_ignored", running, 0);
    do_load(24'h000003);
    do_start();
    repeat (4) step();
    chk("pre_rst_time", time_out, 24'h000002);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrun_rst_time", time_out, 0);
    chk("midrun_rst_nonzero", nonzero, 0);
    chk("midrun_rst_running", running, 0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("midrun_no_exp_%0d", i), expired, 0);
      step();
    end
    chk("midrun_final_alarm", alarm, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
